// File: rtl/dma_tx_frame_reader.sv
// dma_tx_frame_reader
//   Pulls length-prefixed frames from the 64-bit DMA packet FIFO, serialises
//   the payload little-end-byte-first to the MAC TX byte interface and appends
//   the Ethernet FCS (CRC-32, reflected 0xEDB88320).
//
// Optional build macro: DMA_TXF_PAD_EN
//   defined   -> payloads shorter than 60 bytes are zero-padded to 60 (pad is
//                covered by the FCS)
//   undefined -> short payloads go out unpadded
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   fifo_data/empty     FIFO head word and empty flag
//   fifo_pull           pop FIFO head at next clk edge (combinational)
//   tx_data/valid/ready byte stream to MAC, valid/ready handshake
//   tx_sop/tx_eop       first payload byte / last FCS byte
//   len_err             one-cycle pulse when a header length is rejected
//   frame_cnt           frames fully sent (wraps)
//   busy                FSM not in IDLE
//
// state | meaning
// IDLE  | inter-frame gap countdown
// HDR   | pop and check length header
// LOAD  | pop next payload word into shift register
// BYTES | send payload bytes of current word
// PAD   | send zero pad bytes (DMA_TXF_PAD_EN only)
// FCS   | send 4 FCS bytes, LSB first
// DROP  | discard payload words of a rejected frame
module dma_tx_frame_reader #(
  parameter int DWIDTH     = 64,
  parameter int LWIDTH     = 16,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_pull,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop,
  input  logic              tx_ready,
  output logic              len_err,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [LWIDTH-1:0] MAX_L = LWIDTH'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_BYTES,
`ifdef DMA_TXF_PAD_EN
    S_PAD,
`endif
    S_FCS,
    S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ifg_q;
  logic [LWIDTH-1:0]   rem_q;
  logic [LWIDTH:0]     words_q;
  logic [DWIDTH-1:0]   shreg_q;
  logic [2:0]          bidx_q;
  logic [1:0]          fidx_q;
  logic [31:0]         crc_q;
  logic                sop_q;
  logic [15:0]         frame_cnt_q;
`ifdef DMA_TXF_PAD_EN
  logic                short_q;
  logic [5:0]          pad_q;
`endif

  logic [LWIDTH-1:0]   hdr_len;
  logic [LWIDTH:0]     hdr_words;
  logic [31:0]         fcs_w;
  logic [31:0]         crc_upd;
  logic                hs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign hdr_len   = fifo_data[LWIDTH-1:0];
  // word count in LWIDTH+1 bits so L near 2^LWIDTH cannot overflow
  assign hdr_words = ({1'b0, hdr_len} + (LWIDTH+1)'(7)) >> 3;
  assign fcs_w     = ~crc_q;
  assign crc_upd   = crc_byte(crc_q, tx_data);
  assign hs        = tx_valid & tx_ready;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_pull = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    len_err   = 1'b0;
    case (state_q)
      S_IDLE: if (ifg_q == '0) state_d = S_HDR;
      S_HDR: begin
        if (!fifo_empty) begin
          fifo_pull = 1'b1;
          if (hdr_len == '0) begin
            len_err = 1'b1;
            state_d = S_IDLE;
          end else if (hdr_len > MAX_L) begin
            len_err = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (!fifo_empty) begin
          fifo_pull = 1'b1;
          state_d   = S_BYTES;
        end
      end
      S_BYTES: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[7:0];
        tx_sop   = sop_q;
        if (tx_ready) begin
          if (rem_q == LWIDTH'(1)) begin
`ifdef DMA_TXF_PAD_EN
            state_d = short_q ? S_PAD : S_FCS;
`else
            state_d = S_FCS;
`endif
          end else if (bidx_q == 3'd7) begin
            state_d = S_LOAD;
          end
        end
      end
`ifdef DMA_TXF_PAD_EN
      S_PAD: begin
        tx_valid = 1'b1;
        if (tx_ready && pad_q == 6'd1) state_d = S_FCS;
      end
`endif
      S_FCS: begin
        tx_valid = 1'b1;
        case (fidx_q)
          2'd0:    tx_data = fcs_w[7:0];
          2'd1:    tx_data = fcs_w[15:8];
          2'd2:    tx_data = fcs_w[23:16];
          default: tx_data = fcs_w[31:24];
        endcase
        tx_eop = (fidx_q == 2'd3);
        if (tx_ready && fidx_q == 2'd3) state_d = S_IDLE;
      end
      S_DROP: begin
        if (!fifo_empty) begin
          fifo_pull = 1'b1;
          if (words_q == (LWIDTH+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifg_q       <= '0;
      rem_q       <= '0;
      words_q     <= '0;
      shreg_q     <= '0;
      bidx_q      <= '0;
      fidx_q      <= '0;
      crc_q       <= 32'hFFFFFFFF;
      sop_q       <= 1'b0;
      frame_cnt_q <= '0;
`ifdef DMA_TXF_PAD_EN
      short_q     <= 1'b0;
      pad_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ifg_q != '0) ifg_q <= ifg_q - IW'(1);
          else             crc_q <= 32'hFFFFFFFF;
        end
        S_HDR: begin
          if (!fifo_empty) begin
            rem_q   <= hdr_len;
            words_q <= hdr_words;
            sop_q   <= 1'b1;
            fidx_q  <= '0;
`ifdef DMA_TXF_PAD_EN
            short_q <= (hdr_len < LWIDTH'(60));
            pad_q   <= 6'd60 - hdr_len[5:0];
`endif
          end
        end
        S_LOAD: begin
          if (!fifo_empty) begin
            shreg_q <= fifo_data;
            bidx_q  <= '0;
          end
        end
        S_BYTES: begin
          if (hs) begin
            crc_q   <= crc_upd;
            sop_q   <= 1'b0;
            rem_q   <= rem_q - LWIDTH'(1);
            shreg_q <= shreg_q >> 8;
            bidx_q  <= bidx_q + 3'd1;
          end
        end
`ifdef DMA_TXF_PAD_EN
        S_PAD: begin
          if (hs) begin
            crc_q <= crc_upd;
            pad_q <= pad_q - 6'd1;
          end
        end
`endif
        S_FCS: begin
          if (hs) begin
            fidx_q <= fidx_q + 2'd1;
            if (fidx_q == 2'd3) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              ifg_q       <= IW'(IFG_CYCLES);
            end
          end
        end
        S_DROP: begin
          if (!fifo_empty) words_q <= words_q - (LWIDTH+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_tx_frame_reader.sv
module tb_dma_tx_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_pull;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_ready;
  logic        len_err;
  logic [15:0] frame_cnt;
  logic        busy;

  dma_tx_frame_reader dut (
    .clk(clk), .rst(rst),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_ready(tx_ready), .len_err(len_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [7:0] seed;
    int         rmode;
    bit         bad;
    int         exp_len_err;
    int         exp_pops;
    int         exp_fc_inc;
  } vec_t;

  logic [63:0] fq[$];
  logic [7:0]  rx_b[$];
  bit          rx_s[$];
  bit          rx_e[$];
  logic [7:0]  exp_q[$];
  int          sop_cyc[$];
  int          eop_cyc[$];
  bit          stall = 1'b0;
  int          ready_mode = 0;
  int          cyc = 0;
  int          pop_cnt = 0, len_err_cnt = 0, valid_cnt = 0;
  int          mark_pull = 0, mark_valid = 0;
  int          n_vec = 0, n_err = 0;
  int          exp_fc = 0;
  bit          p_stall = 1'b0;
  logic [7:0]  p_data;
  bit          p_sop, p_eop;

  // FIFO model, MAC model and monitor: inputs change at negedge, outputs sampled 1 ns later
  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = cyc[0];
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
    fifo_empty = stall || (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 64'h0;
    #1;
    if (!rst) begin
      if (p_stall) begin
        n_vec++;
        if (!tx_valid || tx_data != p_data || tx_sop != p_sop || tx_eop != p_eop) begin
          n_err++;
          $display("FAIL hold_stable cyc=%0d got v=%b d=%h s=%b e=%b want v=1 d=%h s=%b e=%b",
                   cyc, tx_valid, tx_data, tx_sop, tx_eop, p_data, p_sop, p_eop);
        end
      end
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data; p_sop = tx_sop; p_eop = tx_eop;
      if (fifo_empty) begin
        n_vec++;
        if (fifo_pull) begin
          n_err++;
          $display("FAIL pull_when_empty cyc=%0d got pull=1 want 0", cyc);
        end
      end
      if (fifo_pull && !fifo_empty) begin
        fq.delete(0);
        pop_cnt++;
        if (mark_pull < 0) mark_pull = cyc;
      end
      if (tx_valid) begin
        valid_cnt++;
        if (mark_valid < 0) mark_valid = cyc;
      end
      if (tx_valid && tx_ready) begin
        rx_b.push_back(tx_data);
        rx_s.push_back(tx_sop);
        rx_e.push_back(tx_eop);
        if (tx_sop) sop_cyc.push_back(cyc);
        if (tx_eop) eop_cyc.push_back(cyc);
      end
      if (len_err) len_err_cnt++;
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic push_frame(input int len, input logic [7:0] seed);
    logic [63:0] w;
    int nw;
    fq.push_back({48'hC0FF_EE12_3456, 16'(len)});
    nw = (len + 7) / 8;
    for (int wi = 0; wi < nw; wi++) begin
      for (int k = 0; k < 8; k++)
        w[8*k +: 8] = (wi*8 + k < len) ? seed + 8'(wi*8 + k) : 8'hEE;
      fq.push_back(w);
    end
  endtask

  // reference stream: payload (+pad) then bit-serial CRC-32, LSB byte first
  task automatic build_exp(input int len, input logic [7:0] seed);
    logic [31:0] c;
    bit fb;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(seed + 8'(i));
`ifdef DMA_TXF_PAD_EN
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
    c = 32'hFFFFFFFF;
    foreach (exp_q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ exp_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic check_frame(input string nm, input int len, input logic [7:0] seed);
    int bad_i;
    logic [7:0] g;
    bit s, e;
    logic [7:0] bg;
    bit bs, be;
    build_exp(len, seed);
    n_vec++;
    if (rx_b.size() < exp_q.size()) begin
      n_err++;
      $display("FAIL %s: got %0d bytes, want %0d", nm, rx_b.size(), exp_q.size());
      rx_b.delete(); rx_s.delete(); rx_e.delete();
      return;
    end
    bad_i = -1; bg = 0; bs = 0; be = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = rx_b.pop_front(); s = rx_s.pop_front(); e = rx_e.pop_front();
      if (bad_i < 0 && (g != exp_q[i] || s != (i == 0) || e != (i == exp_q.size() - 1))) begin
        bad_i = i; bg = g; bs = s; be = e;
      end
    end
    if (bad_i >= 0) begin
      n_err++;
      $display("FAIL %s: byte %0d got %h sop=%b eop=%b want %h sop=%b eop=%b", nm, bad_i,
               bg, bs, be, exp_q[bad_i], (bad_i == 0), (bad_i == exp_q.size() - 1));
    end
  endtask

  task automatic wait_fc(input int target, input int budget, input string nm);
    int n = 0;
    while (frame_cnt != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frame_cnt != 16'(target)) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: frame_cnt got %0d want %0d", nm, frame_cnt, target);
    end
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (fq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: fifo words left got %0d want 0", nm, fq.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int b_pop, b_err, b_val, base;
    logic [7:0] t1 [13];
    bit t1_ok;

    rst = 1'b1; tx_ready = 1'b1; fifo_empty = 1'b1; fifo_data = 64'h0;

    vecs[0]  = '{len: 9,    seed: 8'h31, rmode: 1, bad: 0, exp_len_err: 0, exp_pops: 3,   exp_fc_inc: 1};
    vecs[1]  = '{len: 8,    seed: 8'h10, rmode: 0, bad: 0, exp_len_err: 0, exp_pops: 2,   exp_fc_inc: 1};
    vecs[2]  = '{len: 0,    seed: 8'h00, rmode: 0, bad: 1, exp_len_err: 1, exp_pops: 1,   exp_fc_inc: 0};
    vecs[3]  = '{len: 8,    seed: 8'h80, rmode: 0, bad: 0, exp_len_err: 0, exp_pops: 2,   exp_fc_inc: 1};
    vecs[4]  = '{len: 1600, seed: 8'h55, rmode: 0, bad: 1, exp_len_err: 1, exp_pops: 201, exp_fc_inc: 0};
    vecs[5]  = '{len: 1,    seed: 8'hA7, rmode: 0, bad: 0, exp_len_err: 0, exp_pops: 2,   exp_fc_inc: 1};
    vecs[6]  = '{len: 15,   seed: 8'h01, rmode: 1, bad: 0, exp_len_err: 0, exp_pops: 3,   exp_fc_inc: 1};
    vecs[7]  = '{len: 16,   seed: 8'hF0, rmode: 2, bad: 0, exp_len_err: 0, exp_pops: 3,   exp_fc_inc: 1};
    vecs[8]  = '{len: 1515, seed: 8'h22, rmode: 0, bad: 1, exp_len_err: 1, exp_pops: 191, exp_fc_inc: 0};
    vecs[9]  = '{len: 1514, seed: 8'h3C, rmode: 2, bad: 0, exp_len_err: 0, exp_pops: 191, exp_fc_inc: 1};
    vecs[10] = '{len: 59,   seed: 8'h90, rmode: 1, bad: 0, exp_len_err: 0, exp_pops: 9,   exp_fc_inc: 1};
    vecs[11] = '{len: 60,   seed: 8'h07, rmode: 0, bad: 0, exp_len_err: 0, exp_pops: 9,   exp_fc_inc: 1};

    t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({tx_valid, tx_sop, tx_eop, tx_data, fifo_pull, len_err, frame_cnt, busy}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // known-answer frame and header-to-first-byte latency
    mark_pull = -1; mark_valid = -1;
`ifndef DMA_TXF_PAD_EN
    fq.push_back(64'h0000_0000_0000_0009);
    fq.push_back(64'h3837_3635_3433_3231);
    fq.push_back(64'h0000_0000_0000_0039);
    exp_fc = 1;
    wait_fc(exp_fc, 200, "kat");
    n_vec++;
    t1_ok = (rx_b.size() == 13);
    for (int i = 0; i < 13 && t1_ok; i++)
      if (rx_b[i] != t1[i] || rx_s[i] != (i == 0) || rx_e[i] != (i == 12)) t1_ok = 1'b0;
    if (!t1_ok) begin
      n_err++;
      $display("FAIL kat_bytes: got %0d bytes first=%h last=%h want 13 bytes 31..39 26 39 f4 cb",
               rx_b.size(), (rx_b.size() > 0) ? rx_b[0] : 8'h0,
               (rx_b.size() > 0) ? rx_b[rx_b.size()-1] : 8'h0);
    end
    rx_b.delete(); rx_s.delete(); rx_e.delete();
`else
    push_frame(10, 8'h41);
    exp_fc = 1;
    wait_fc(exp_fc, 300, "pad10");
    chk("pad10_len", rx_b.size(), 64);
    check_frame("pad10_bytes", 10, 8'h41);
`endif
    chk("kat_latency", mark_valid - mark_pull, 2);
    chk("kat_frame_cnt", frame_cnt, 1);

    // table-driven frames
    foreach (vecs[v]) begin
      b_pop = pop_cnt; b_err = len_err_cnt; b_val = valid_cnt;
      ready_mode = vecs[v].rmode;
      push_frame(vecs[v].len, vecs[v].seed);
      if (vecs[v].bad) begin
        wait_drain(vecs[v].len + 100, $sformatf("v%0d", v));
        chk($sformatf("v%0d_no_valid", v), valid_cnt - b_val, 0);
      end else begin
        exp_fc += vecs[v].exp_fc_inc;
        wait_fc(exp_fc, vecs[v].len * 6 + 200, $sformatf("v%0d", v));
        check_frame($sformatf("v%0d_bytes", v), vecs[v].len, vecs[v].seed);
      end
      chk($sformatf("v%0d_len_err", v), len_err_cnt - b_err, vecs[v].exp_len_err);
      chk($sformatf("v%0d_pops", v), pop_cnt - b_pop, vecs[v].exp_pops);
      chk($sformatf("v%0d_frame_cnt", v), frame_cnt, exp_fc);
    end
    ready_mode = 0;

    // back-to-back frames, underrun in the second one
    sop_cyc.delete(); eop_cyc.delete();
    b_err = len_err_cnt; base = pop_cnt;
    push_frame(64, 8'h11);
    push_frame(64, 8'h99);
    begin
      int n = 0;
      while (pop_cnt < base + 10 && n < 400) begin @(negedge clk); n++; end
    end
    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    exp_fc += 2;
    wait_fc(exp_fc, 600, "b2b");
    check_frame("b2b_f1", 64, 8'h11);
    check_frame("b2b_f2", 64, 8'h99);
    chk("b2b_len_err", len_err_cnt - b_err, 0);
    if (sop_cyc.size() >= 2 && eop_cyc.size() >= 1) begin
      n_vec++;
      if (sop_cyc[1] - eop_cyc[0] < 13) begin
        n_err++;
        $display("FAIL ifg_gap: got %0d cycles eop->sop want >= 13", sop_cyc[1] - eop_cyc[0]);
      end
      chk("rate_sop_to_eop", eop_cyc[0] - sop_cyc[0], 74);
    end else begin
      n_vec++; n_err++;
      $display("FAIL b2b_markers: got sop=%0d eop=%0d want >=2 and >=1", sop_cyc.size(), eop_cyc.size());
    end

    // async reset in the middle of a frame
    push_frame(64, 8'h5A);
    begin
      int n = 0;
      while (rx_b.size() < 5 && n < 400) begin @(negedge clk); n++; end
      chk("mid_reset_started", int'(rx_b.size() >= 5), 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outputs", int'({tx_valid, tx_sop, tx_eop, tx_data, fifo_pull, len_err, frame_cnt, busy}), 0);
    @(negedge clk);
    fq.delete(); rx_b.delete(); rx_s.delete(); rx_e.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 1;
    push_frame(20, 8'hC3);
    wait_fc(exp_fc, 400, "post_reset");
    check_frame("post_reset_bytes", 20, 8'hC3);
    chk("post_reset_frame_cnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_tx_frame_reader.md
Name: dma_tx_frame_reader

Overview:
- Pull-side consumer of the 64-bit DMA packet FIFO. Reads one length-header word per frame, then that frame's payload words.
- Serialises the payload to a byte stream for the MAC transmit path and appends the Ethernet FCS (CRC-32).
- Sits between the DMA FIFO read port (data_out/empty/pull) and the MAC TX byte interface.

Parameters:
- DWIDTH, 64, FIFO word width; only 64 is supported.
- LWIDTH, 16, width of the header length field.
- MAX_LEN, 1514, largest legal payload length in bytes (FCS excluded).
- IFG_CYCLES, 12, minimum idle clocks between a tx_eop handshake and the next tx_sop.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous reset, active-high.
- fifo_data  in  DWIDTH  FIFO head word; valid combinationally whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pull  out  1  pops the FIFO head at the next clk edge.
- tx_data  out  8  byte to MAC.
- tx_valid  out  1  tx_data is valid.
- tx_sop  out  1  first byte of frame.
- tx_eop  out  1  last FCS byte.
- tx_ready  in  1  MAC accepts the byte when tx_valid&tx_ready.
- len_err  out  1  one-cycle pulse when a header is rejected.
- frame_cnt  out  16  count of frames fully sent; wraps 0xFFFF->0.
- busy  out  1  state != IDLE.

Behaviour:
- Word format:
  - Header: bits [LWIDTH-1:0] = payload byte length L; upper bits ignored.
  - Payload: W = ceil(L/8) words, computed in LWIDTH+1 bits. Byte k of a word is bits [8k+7:8k], and byte 0 is sent first.
  - Bytes in the last word beyond L are discarded.
- fifo_pull is combinational: it is asserted only in HDR or LOAD (and DROP) when fifo_empty=0. It is never asserted while fifo_empty=1.
- States:
  - IDLE: wait for the IFG counter to reach 0. Then go to HDR.
  - HDR: when fifo_empty=0, pop and capture L.
    - L=0: pulse len_err, go to IDLE.
    - L>MAX_LEN: pulse len_err, go to DROP with W words.
    - Otherwise: go to LOAD.
  - LOAD: when fifo_empty=0, pop the word into the shift register and set byte index=0. Go to BYTES the next cycle.
  - BYTES: present the current byte with tx_valid=1. On handshake, update CRC and advance.
    - After the last byte of the word: go to LOAD if payload remains.
    - After payload byte L: go to FCS.
  - FCS: emit ~crc as 4 bytes, crc[7:0] first. On handshake of byte 3, assert tx_eop on that byte, increment frame_cnt, load the IFG counter with IFG_CYCLES, and go to IDLE.
  - DROP: pop W words as they become available, emitting nothing. Then go to IDLE.
- Output holding:
  - tx_data/tx_sop/tx_eop stay stable while tx_valid=1 and tx_ready=0.
  - tx_sop=1 only on payload byte 0.
  - tx_valid drops to 0 in LOAD. FIFO underrun mid-frame stalls the stream and is not an error.
- CRC: IEEE 802.3, polynomial 0x04C11DB7 reflected (0xEDB88320), init 0xFFFFFFFF, byte-wise LSB-first update, final complement. Re-initialised on entry to HDR.
- Latency: header pop to first tx_valid is 2 cycles when the FIFO is non-empty. Steady rate is 8 bytes per 9 cycles with tx_ready=1.
- Reset (async, any state, mid-frame included):
  - State=IDLE, IFG counter=0, crc=0xFFFFFFFF.
  - tx_valid/sop/eop=0, tx_data=0, fifo_pull=0, len_err=0, frame_cnt=0, busy=0.
  - Partially read frames are lost; upstream must flush the FIFO together with this block.

Optional Feature:
- Macro: DMA_TXF_PAD_EN.
- Defined: if L<60, after payload byte L the block emits (60-L) bytes of 0x00 in state PAD, then FCS. The CRC covers the pad. On the wire, frame length is max(L,60)+4.
- Undefined: no PAD state; frames shorter than 60 bytes are sent unpadded.

Test Plan:
1. Header L=9, words 0x3837363534333231 and 0x0000000000000039, tx_ready=1 -> bytes 31..39 then 26 39 F4 CB; sop on 0x31, eop on 0xCB; frame_cnt=1.
2. Same frame with tx_ready toggling 1/0 each cycle -> identical byte sequence; no byte duplicated or dropped; outputs stable while stalled.
3. Header L=0, then a valid L=8 frame -> len_err pulses once; only the second frame is transmitted; frame_cnt=1.
4. Header L=1600 (MAX_LEN=1514) -> len_err=1, exactly 200 words popped, no tx_valid; the next frame is sent normally.
5. Two back-to-back L=64 frames, FIFO emptied for 5 cycles mid-frame, plus rst asserted during a third frame -> tx_sop gap is at least 12 cycles; the underrun stalls without error; after rst all outputs are 0 and state is IDLE.
6. With DMA_TXF_PAD_EN defined, L=10 -> 10 data bytes + 50 bytes of 0x00 + 4 FCS bytes, with FCS computed over all 60 bytes.
